// File: rtl/pong_step_timer.sv
// Step-strobe, game-over timeout and blink-phase timer for the Pong light FSM.
// Enables pick the mode each edge; the step period shrinks with level down to a floor.
module pong_step_timer #(
  parameter int unsigned STEP_BASE    = 20_000_000,
  parameter int unsigned STEP_DEC     = 1_000_000,
  parameter int unsigned STEP_MIN     = 4_000_000,
  parameter int unsigned END_CYCLES   = 500_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic       Clk,
  input  logic       r,
  input  logic       EnTimer20,
  input  logic       EnTimer5,
  input  logic [3:0] level,
  output logic       Time20,
  output logic       Time5,
  output logic       Blink
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_END} state_t;

  localparam logic [31:0] END_LAST   = 32'(END_CYCLES - 1);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);
  localparam logic [31:0] SPAN       = 32'(STEP_BASE - STEP_MIN);

  state_t      state_q, state_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] per_q, per_d;
  logic [31:0] end_cnt_q, end_cnt_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        time20_q, time20_d;
  logic        time5_q, time5_d;
  logic        blink_q, blink_d;

  logic [31:0] lvl_dec, per_new, per_eff;
  logic        end_done;

  // Clamp before subtracting so a high level can never underflow the period.
  assign lvl_dec  = 32'(level) * 32'(STEP_DEC);
  assign per_new  = (lvl_dec > SPAN) ? 32'(STEP_MIN) : 32'(STEP_BASE) - lvl_dec;
  // On entry to stepping the period comes straight from the current level.
  assign per_eff  = (state_q == S_STEP) ? per_q : per_new;
  assign end_done = (end_cnt_q == END_LAST);

  always_comb begin
    state_d     = S_IDLE;
    step_cnt_d  = '0;
    per_d       = per_q;
    end_cnt_d   = '0;
    blink_cnt_d = '0;
    time20_d    = 1'b0;
    time5_d     = 1'b0;
    blink_d     = 1'b0;
    if (EnTimer5) begin
      state_d = S_END;
      if (end_done) begin
        // Timeout reached: hold the flag and freeze the blink phase.
        end_cnt_d   = end_cnt_q;
        time5_d     = 1'b1;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
      end else begin
        end_cnt_d = end_cnt_q + 32'd1;
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 32'd1;
          blink_d     = blink_q;
        end
      end
    end else if (EnTimer20) begin
      state_d = S_STEP;
      if (step_cnt_q == per_eff - 32'd1) begin
        step_cnt_d = '0;
        time20_d   = 1'b1;
        per_d      = per_new;
      end else begin
        step_cnt_d = step_cnt_q + 32'd1;
        per_d      = per_eff;
      end
    end
  end

  always_ff @(posedge Clk or posedge r) begin
    if (r) begin
      state_q     <= S_IDLE;
      step_cnt_q  <= '0;
      per_q       <= '0;
      end_cnt_q   <= '0;
      blink_cnt_q <= '0;
      time20_q    <= 1'b0;
      time5_q     <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      per_q       <= per_d;
      end_cnt_q   <= end_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      time20_q    <= time20_d;
      time5_q     <= time5_d;
      blink_q     <= blink_d;
    end
  end

  assign Time20 = time20_q;
  assign Time5  = time5_q;
  assign Blink  = blink_q;

endmodule

// File: tb/tb_pong_step_timer.sv
// Bench for pong_step_timer: period table, directed corner sequences and a
// randomized run, all compared against an elapsed-time reference model.
module tb_pong_step_timer;

  localparam int BASE = 10, DEC = 2, PMIN = 4, ENDC = 30, BLK = 5;

  logic       Clk = 1'b0;
  logic       r = 1'b1;
  logic       EnTimer20 = 1'b0;
  logic       EnTimer5 = 1'b0;
  logic [3:0] level = 4'd0;
  logic       Time20, Time5, Blink;

  pong_step_timer #(
    .STEP_BASE(BASE), .STEP_DEC(DEC), .STEP_MIN(PMIN),
    .END_CYCLES(ENDC), .BLINK_CYCLES(BLK)
  ) dut (
    .Clk(Clk), .r(r), .EnTimer20(EnTimer20), .EnTimer5(EnTimer5),
    .level(level), .Time20(Time20), .Time5(Time5), .Blink(Blink)
  );

  always #5 Clk = ~Clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: time elapsed in the current period / in the end phase.
  int   m_mode = 0;   // 0 idle, 1 stepping, 2 game over
  int   m_el = 0;
  int   m_per = BASE;
  int   m_end = 0;
  logic m_t20 = 1'b0;

  function automatic int per_of(input int lv);
    return (lv * DEC > BASE - PMIN) ? PMIN : BASE - lv * DEC;
  endfunction

  function automatic logic m_t5();
    return m_end >= ENDC;
  endfunction

  // Toggles happen at end-phase edges k*BLK strictly below ENDC.
  function automatic logic m_blink();
    int e;
    e = (m_end < ENDC) ? m_end : ENDC - 1;
    return ((e / BLK) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_el = 0; m_end = 0; m_t20 = 1'b0;
  endtask

  task automatic model_update(input logic e20, input logic e5, input int lv);
    m_t20 = 1'b0;
    if (e5) begin
      m_el = 0;
      if (m_end < 1000) m_end++;
      m_mode = 2;
    end else if (e20) begin
      if (m_mode != 1) begin
        m_el  = 0;
        m_per = per_of(lv);
      end
      m_el++;
      if (m_el == m_per) begin
        m_t20 = 1'b1;
        m_el  = 0;
        m_per = per_of(lv);
      end
      m_end  = 0;
      m_mode = 1;
    end else begin
      m_el = 0; m_end = 0; m_mode = 0;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, clock once, compare against the model.
  task automatic tick(input logic e20, input logic e5, input logic [3:0] lv);
    EnTimer20 = e20; EnTimer5 = e5; level = lv;
    @(posedge Clk);
    model_update(e20, e5, int'(lv));
    @(negedge Clk);
    chk("m_time20", Time20, m_t20);
    chk("m_time5", Time5, m_t5());
    chk("m_blink", Blink, m_blink());
  endtask

  task automatic do_reset();
    r = 1'b1;
    #1;
    model_reset();
    chk("rst_time20", Time20, 1'b0);
    chk("rst_time5", Time5, 1'b0);
    chk("rst_blink", Blink, 1'b0);
    #1 r = 1'b0;
  endtask

  typedef struct {
    logic [3:0] lv;
    int         per;
  } per_vec_t;

  per_vec_t tab[7];

  initial begin
    tab[0] = '{4'd0, 10};
    tab[1] = '{4'd1, 8};
    tab[2] = '{4'd2, 6};
    tab[3] = '{4'd3, 4};
    tab[4] = '{4'd4, 4};
    tab[5] = '{4'd7, 4};
    tab[6] = '{4'd15, 4};

    #1;
    chk("por_time20", Time20, 1'b0);
    chk("por_time5", Time5, 1'b0);
    chk("por_blink", Blink, 1'b0);
    @(negedge Clk);
    r = 1'b0;
    model_reset();

    // Level 0: strobes at 10, 20, 30 only.
    for (int k = 1; k <= 35; k++) begin
      tick(1'b1, 1'b0, 4'd0);
      chk("lvl0_time20", Time20, (k % 10) == 0);
    end

    // Period per level, including the clamp.
    foreach (tab[i]) begin
      tick(1'b0, 1'b0, 4'd0);
      for (int k = 1; k <= 2 * tab[i].per + 1; k++) begin
        tick(1'b1, 1'b0, tab[i].lv);
        chk("tab_time20", Time20, (k % tab[i].per) == 0);
      end
    end

    // Level change mid-period only affects the next period.
    tick(1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 17; k++) begin
      tick(1'b1, 1'b0, (k <= 5) ? 4'd0 : 4'd2);
      chk("lvlchg_time20", Time20, (k == 10) || (k == 16));
    end

    // Reset with the count at 7 loses the partial period.
    tick(1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 7; k++) tick(1'b1, 1'b0, 4'd0);
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      tick(1'b1, 1'b0, 4'd0);
      chk("rstmid_time20", Time20, k == 10);
    end

    // Timeout and blink.
    tick(1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, 1'b1, 4'd0);
      chk("end_time5", Time5, k >= 30);
      chk("end_blink", Blink, (((k < 30 ? k : 29) / 5) % 2) == 1);
    end
    tick(1'b0, 1'b0, 4'd0);
    chk("endrel_time5", Time5, 1'b0);
    chk("endrel_blink", Blink, 1'b0);

    // Reset while Blink is high.
    for (int k = 1; k <= 27; k++) tick(1'b0, 1'b1, 4'd0);
    chk("pre_rst_blink", Blink, 1'b1);
    do_reset();

    // Both enables: game-over mode wins.
    for (int k = 1; k <= 35; k++) begin
      tick(1'b1, 1'b1, 4'd0);
      chk("both_time20", Time20, 1'b0);
      chk("both_time5", Time5, k >= 30);
    end

    // Step -> end -> step discards the partial period.
    tick(1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 8; k++) tick(1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 3; k++) tick(1'b0, 1'b1, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      tick(1'b1, 1'b0, 4'd0);
      chk("switch_time20", Time20, k == 10);
    end

    // Randomized segments against the model.
    for (int s = 0; s < 150; s++) begin
      int sel, len;
      logic [3:0] lv;
      if ($urandom_range(0, 19) == 0) do_reset();
      sel = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 40));
      lv  = 4'($urandom_range(0, 15));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 15) == 0) lv = 4'($urandom_range(0, 15));
        case (sel)
          0, 1:    tick(1'b0, 1'b0, lv);
          2, 3, 4, 5: tick(1'b1, 1'b0, lv);
          6, 7, 8: tick(1'b0, 1'b1, lv);
          default: tick(1'b1, 1'b1, lv);
        endcase
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
